framebuffer_scanout: RTL



---
 rtl/framebuffer_scanout.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: raster timing generator with integer-upscaled framebuffer readout.
// Define FRAMEBUFFER_SCANOUT_TEST_PATTERN_EN to add a colour-bar override input (test_pattern).
module framebuffer_scanout #(
    parameter int unsigned DISPLAY_WIDTH         = 100,
    parameter int unsigned DISPLAY_HEIGHT        = 100,
    parameter int unsigned FRAMEBUFFER_DATA_BITS = 16,
    parameter int unsigned FRAMEBUFFER_ADDR_BITS = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT),
    parameter int unsigned PIXEL_SCALE           = 4,
    parameter logic [FRAMEBUFFER_DATA_BITS-1:0] BORDER_COLOR = '0,
    parameter int unsigned H_ACTIVE              = 640,
    parameter int unsigned H_FRONT               = 16,
    parameter int unsigned H_SYNC                = 96,
    parameter int unsigned H_BACK                = 48,
    parameter int unsigned V_ACTIVE              = 480,
    parameter int unsigned V_FRONT               = 10,
    parameter int unsigned V_SYNC                = 2,
    parameter int unsigned V_BACK                = 33
) (
    input  logic                             clk,
    input  logic                             rst,
`ifdef FRAMEBUFFER_SCANOUT_TEST_PATTERN_EN
    input  logic                             test_pattern,
`endif
    output logic [FRAMEBUFFER_ADDR_BITS-1:0] framebuffer_rd_addr,
    input  logic [FRAMEBUFFER_DATA_BITS-1:0] framebuffer_rd_data,
    output logic [FRAMEBUFFER_DATA_BITS-1:0] pixel_data,
    output logic                             hsync,
    output logic                             vsync,
    output logic                             de,
    output logic                             vblank,
    output logic                             frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned SW      = (PIXEL_SCALE > 1) ? $clog2(PIXEL_SCALE) : 1;
    localparam int unsigned CW      = $clog2(DISPLAY_WIDTH + 1);
    localparam int unsigned RW      = $clog2(DISPLAY_HEIGHT + 1);
    localparam int unsigned AW      = FRAMEBUFFER_ADDR_BITS;
    localparam int unsigned DW      = FRAMEBUFFER_DATA_BITS;

    typedef enum logic [1:0] {HAct, HFp, HSync, HBp} h_state_e;
    typedef enum logic [1:0] {VAct, VFp, VSync, VBp} v_state_e;

    h_state_e      h_state_q, h_state_d;
    v_state_e      v_state_q, v_state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [SW-1:0] col_sub_q, col_sub_d, row_sub_q, row_sub_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [AW-1:0] row_base_q, row_base_d, rd_addr_d;
    logic          line_end, in_img, in_img_d;

    // Pipeline stage between counters and output registers.
    logic          de_p, hsync_p, vsync_p, vblank_p, fs_p, img_p;
    logic [DW-1:0] img_pixel;

    function automatic logic in_image(h_state_e hs, v_state_e vs, logic [CW-1:0] c,
                                      logic [RW-1:0] r);
        return (hs == HAct) && (vs == VAct) && (c < CW'(DISPLAY_WIDTH)) &&
               (r < RW'(DISPLAY_HEIGHT));
    endfunction

    always_comb begin
        h_state_d  = h_state_q;
        v_state_d  = v_state_q;
        h_cnt_d    = h_cnt_q + HW'(1);
        v_cnt_d    = v_cnt_q;
        col_sub_d  = col_sub_q + SW'(1);
        col_d      = col_q;
        row_sub_d  = row_sub_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        line_end   = (h_cnt_q == HW'(H_TOTAL - 1));

        unique case (h_state_q)
            HAct:    if (h_cnt_q == HW'(H_ACTIVE - 1)) h_state_d = HFp;
            HFp:     if (h_cnt_q == HW'(H_ACTIVE + H_FRONT - 1)) h_state_d = HSync;
            HSync:   if (h_cnt_q == HW'(H_ACTIVE + H_FRONT + H_SYNC - 1)) h_state_d = HBp;
            HBp:     if (line_end) h_state_d = HAct;
            default: h_state_d = HAct;
        endcase

        // Column saturates one past the image so the image test is a simple compare.
        if (col_sub_q == SW'(PIXEL_SCALE - 1)) begin
            col_sub_d = '0;
            if (col_q != CW'(DISPLAY_WIDTH)) col_d = col_q + CW'(1);
        end

        if (line_end) begin
            h_cnt_d   = '0;
            col_sub_d = '0;
            col_d     = '0;
            v_cnt_d   = v_cnt_q + VW'(1);
            row_sub_d = row_sub_q + SW'(1);
            if (row_sub_q == SW'(PIXEL_SCALE - 1)) begin
                row_sub_d = '0;
                if (row_q != RW'(DISPLAY_HEIGHT)) begin
                    row_d      = row_q + RW'(1);
                    row_base_d = row_base_q + AW'(DISPLAY_WIDTH);
                end
            end
            unique case (v_state_q)
                VAct:  if (v_cnt_q == VW'(V_ACTIVE - 1)) v_state_d = VFp;
                VFp:   if (v_cnt_q == VW'(V_ACTIVE + V_FRONT - 1)) v_state_d = VSync;
                VSync: if (v_cnt_q == VW'(V_ACTIVE + V_FRONT + V_SYNC - 1)) v_state_d = VBp;
                VBp: begin
                    if (v_cnt_q == VW'(V_TOTAL - 1)) begin
                        v_state_d  = VAct;
                        v_cnt_d    = '0;
                        row_sub_d  = '0;
                        row_d      = '0;
                        row_base_d = '0;
                    end
                end
                default: v_state_d = VAct;
            endcase
        end

        // Address is registered alongside the counters so it matches the current position.
        in_img_d  = in_image(h_state_d, v_state_d, col_d, row_d);
        rd_addr_d = in_img_d ? (row_base_d + AW'(col_d)) : '0;
        in_img    = in_image(h_state_q, v_state_q, col_q, row_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_state_q           <= HAct;
            v_state_q           <= VAct;
            h_cnt_q             <= '0;
            v_cnt_q             <= '0;
            col_sub_q           <= '0;
            col_q               <= '0;
            row_sub_q           <= '0;
            row_q               <= '0;
            row_base_q          <= '0;
            framebuffer_rd_addr <= '0;
        end else begin
            h_state_q           <= h_state_d;
            v_state_q           <= v_state_d;
            h_cnt_q             <= h_cnt_d;
            v_cnt_q             <= v_cnt_d;
            col_sub_q           <= col_sub_d;
            col_q               <= col_d;
            row_sub_q           <= row_sub_d;
            row_q               <= row_d;
            row_base_q          <= row_base_d;
            framebuffer_rd_addr <= rd_addr_d;
        end
    end

`ifdef FRAMEBUFFER_SCANOUT_TEST_PATTERN_EN
    localparam int unsigned REP = (DW + 2) / 3;
    logic [2:0]       bar_p;
    logic [3*REP-1:0] bar_rep;

    always_ff @(posedge clk) begin
        if (rst) bar_p <= '0;
        else     bar_p <= 3'(col_q);
    end

    assign bar_rep = {REP{bar_p}};

    always_comb begin
        img_pixel = framebuffer_rd_data;
        if (test_pattern) img_pixel = bar_rep[DW-1:0];
    end
`else
    assign img_pixel = framebuffer_rd_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            de_p     <= 1'b0;
            hsync_p  <= 1'b1;
            vsync_p  <= 1'b1;
            vblank_p <= 1'b0;
            fs_p     <= 1'b0;
            img_p    <= 1'b0;
        end else begin
            de_p     <= (h_state_q == HAct) && (v_state_q == VAct);
            hsync_p  <= (h_state_q != HSync);
            vsync_p  <= (v_state_q != VSync);
            vblank_p <= (v_state_q != VAct);
            fs_p     <= (h_cnt_q == '0) && (v_cnt_q == '0);
            img_p    <= in_img;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_data  <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hsync_p;
            vsync       <= vsync_p;
            de          <= de_p;
            vblank      <= vblank_p;
            frame_start <= fs_p;
            if (img_p)     pixel_data <= img_pixel;
            else if (de_p) pixel_data <= BORDER_COLOR;
            else           pixel_data <= '0;
        end
    end

endmodule
